// File: rtl/data_split.sv
// Wide-to-narrow width converter: each IW_WIDTH word is emitted as IW_WIDTH/OW_WIDTH
// slices, MSB slice first, with a one-word pending buffer behind the shift register.
module data_split #(
  parameter int IW_WIDTH = 64,
  parameter int OW_WIDTH = 32
) (
  input  logic                I_Clk,
  input  logic                I_Rst,
  input  logic                I_Data_De,
  input  logic [IW_WIDTH-1:0] I_Data,
  output logic                O_Ready,
  output logic                O_Data_De,
  output logic [OW_WIDTH-1:0] O_Data,
  output logic                O_Last,
  input  logic                I_Ready
);

  localparam int NUM = IW_WIDTH / OW_WIDTH;
  localparam logic [7:0] LAST_CNT = 8'(NUM - 1);

  typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;

  state_t              state;
  logic [IW_WIDTH-1:0] sreg;
  logic [IW_WIDTH-1:0] pend;
  logic [7:0]          cnt;
  logic                accept;
  logic                xfer;
  logic                last_xfer;

  assign accept    = I_Data_De && O_Ready;
  assign xfer      = O_Data_De && I_Ready;
  assign last_xfer = xfer && (cnt == LAST_CNT);

  assign O_Data = sreg[IW_WIDTH-1 -: OW_WIDTH];
  // Gated by valid so an idle block never flags Last, even when NUM == 1.
  assign O_Last = O_Data_De && (cnt == LAST_CNT);

  // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge I_Clk or posedge I_Rst) begin
    if (I_Rst) begin
      state     <= EMPTY;
      sreg      <= '0;
      pend      <= '0;
      cnt       <= '0;
      O_Ready   <= 1'b1;
      O_Data_De <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            sreg      <= I_Data;
            cnt       <= '0;
            state     <= BUSY;
            O_Data_De <= 1'b1;
          end
        end
        BUSY: begin
          if (last_xfer) begin
            cnt <= '0;
            if (accept) begin
              sreg <= I_Data;
            end else begin
              state     <= EMPTY;
              O_Data_De <= 1'b0;
            end
          end else begin
            if (xfer) begin
              sreg <= sreg << OW_WIDTH;
              cnt  <= cnt + 8'd1;
            end
            if (accept) begin
              pend    <= I_Data;
              state   <= FULL;
              O_Ready <= 1'b0;
            end
          end
        end
        FULL: begin
          if (last_xfer) begin
            sreg    <= pend;
            cnt     <= '0;
            state   <= BUSY;
            O_Ready <= 1'b1;
          end else if (xfer) begin
            sreg <= sreg << OW_WIDTH;
            cnt  <= cnt + 8'd1;
          end
        end
        default: begin
          state     <= EMPTY;
          O_Ready   <= 1'b1;
          O_Data_De <= 1'b0;
        end
      endcase
    end
  end

endmodule
